lcd_status_sequencer: RTL and testbench
=======================================

Name: lcd_status_sequencer

Overview:
- Owns the write port of the 32-character LCD RAM (2 lines x 16) that is scanned by the LCD display driver.
- Shares that single write port between two requesters: score updates, which render an 8-bit score as three ASCII decimal digits, and game-status updates, which rewrite line 2 with a fixed 16-character message.
- Sits in the top level between the system core (score, status) and the LCD RAM. It replaces the current constant-address, always-enabled write.

Parameters:
- ADDR_W, 5, LCD RAM address width (32 cells).
- SCORE_W, 8, score input width; the value range is 0..255.
- SCORE_COL, 7, LCD address of the hundreds digit; tens is at SCORE_COL+1 and ones at SCORE_COL+2.
- STATUS_BASE, 16, first LCD address of the status line.

Ports:
- CLOCK_50  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- score  in  SCORE_W  current game score (binary).
- status  in  2  game state: 0 = idle, 1 = playing, 2 = game over, 3 = paused.
- lcd_waddr  out  ADDR_W  LCD RAM write address.
- lcd_din  out  8  ASCII byte to write.
- lcd_we  out  1  write strobe; one character is written per cycle while high.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- All outputs are registered.
- Reset values: lcd_we=0, lcd_waddr=0, lcd_din=8'h20, busy=1. After reset the FSM is in INIT.
- Internal registers:
  - last_score (SCORE_W) and score_ok: score_ok is cleared by reset.
  - last_status (2 bits) and status_ok: status_ok is cleared by reset.
- Pending flags (combinational):
  - score_pend = !score_ok or score != last_score.
  - stat_pend = !status_ok or status != last_status.
- INIT state:
  - Writes addresses 0..15 on consecutive cycles: 16 cycles, lcd_we=1 on each.
  - Data is the line-1 template "SCORE:" followed by ten spaces.
  - Then goes to IDLE.
- IDLE state:
  - busy=0, lcd_we=0.
  - If score_pend, go to CONV_H. Score has fixed priority when both are pending.
  - Else if stat_pend, go to STAT_WR.
  - Else stay in IDLE.
- Score path:
  - On entry to CONV_H, snapshot score into rem and last_score, set score_ok=1, and clear hund and tens.
  - CONV_H: each cycle, if rem >= 100 then rem -= 100 and hund++; else go to CONV_T.
  - CONV_T: same rule with 10 and tens; on exit go to DIG_WR.
  - Snapshotting at CONV_H entry means a score change during conversion or write is caught as a new score_pend once the FSM returns to IDLE. No update is lost and no partial value is displayed.
  - DIG_WR writes three characters on 3 consecutive cycles:
    - SCORE_COL: "0"+hund, or space if hund==0 (leading-zero blank).
    - SCORE_COL+1: "0"+tens, or space if hund==0 and tens==0.
    - SCORE_COL+2: "0"+rem. The ones digit is always printed.
  - Then return to IDLE.
  - Latency from IDLE to the last digit write = 1 + (hund+1) + (tens+1) + 3 cycles. Worst case, score=199: 1+2+10+3 = 16.
- Status path:
  - On entry to STAT_WR, snapshot status into last_status and set status_ok=1.
  - STAT_WR writes STATUS_BASE..STATUS_BASE+15 on 16 consecutive cycles from the message ROM, then returns to IDLE.
  - Messages, each space-padded to 16 characters:
    - 0: "PRESS SPACE"
    - 1: "PLAYING"
    - 2: "GAME OVER"
    - 3: "PAUSED"
- A request is never pre-empted. A write burst always completes. The other requester waits in its pending state.
- Address counters wrap within ADDR_W. No address outside the 0..31 range is written.
- Reset asserted mid-burst:
  - lcd_we drops to 0 on the next edge and the FSM restarts at INIT.
  - The RAM content is rewritten in full: line 1 by INIT, then the score digits and line 2 because score_ok and status_ok are clear.
- Expected order after reset: INIT (16 writes), then the score (digits), then the status line (16 writes).

Decomposition:
- Shared package lcd_pkg:
  - Constants: LCD_CELLS=32, LINE_LEN=16, ASCII_SPACE=8'h20, ASCII_ZERO=8'h30.
  - Status codes: ST_IDLE, ST_PLAY, ST_OVER, ST_PAUSE.
  - FSM state encoding: INIT, IDLE, CONV_H, CONV_T, DIG_WR, STAT_WR.
- One sub-module, lcd_text_rom: a combinational ROM indexed by {sel[2:0], col[3:0]} that returns ASCII.
  - Entries 0..3 are the status messages; entry 4 is the line-1 template.
  - Used by both INIT and STAT_WR.

Test Plan:
- Reset, status=0, score=0 -> 16 writes to addrs 0..15 ("SCORE:" + spaces), then addrs 7,8,9 = 20h,20h,30h, then addrs 16..31 = "PRESS SPACE" + 5 spaces; then busy=0.
- Idle, then score changes to 255 -> after 1+3+6 = 10 cycles of conversion, writes 7="2", 8="5", 9="5"; exactly 3 we pulses.
- Score=199 and status 1->2 in the same cycle -> the digit burst "199" completes first (16-cycle latency), then the status burst "GAME OVER" + 7 spaces at 16..31; no interleaving of addresses.
- Score changes 10->11 during DIG_WR of 10 -> the "10" writes complete, then a second conversion writes " 11" (8=1, 9=1); final displayed value is 11.
- Reset asserted on the 5th cycle of STAT_WR -> lcd_we=0 on the next edge, then a full INIT + score + status sequence reruns.
- Score=5 -> 7=space, 8=space, 9="5"; score=40 -> 7=space, 8="4", 9="0".

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD status sequencer: character constants,
// game-status codes, the sequencer state encoding and a digit helper.
package lcd_pkg;

   localparam int LCD_CELLS = 32;
   localparam int LINE_LEN  = 16;

   localparam logic [7:0] ASCII_SPACE = 8'h20;
   localparam logic [7:0] ASCII_ZERO  = 8'h30;

   // ROM selector for the line-1 template; selectors 0..3 are the status messages
   localparam logic [2:0] SEL_TEMPLATE = 3'd4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PLAY  = 2'd1,
      ST_OVER  = 2'd2,
      ST_PAUSE = 2'd3
   } status_e;

   typedef enum logic [2:0] {
      INIT    = 3'd0,
      IDLE    = 3'd1,
      CONV_H  = 3'd2,
      CONV_T  = 3'd3,
      DIG_WR  = 3'd4,
      STAT_WR = 3'd5
   } lcd_state_e;

   // Turns a single decimal digit (0..9) into its ASCII character
   function automatic logic [7:0] digitChar(input logic [3:0] digit);
      return ASCII_ZERO + {4'b0000, digit};
   endfunction

endpackage

// File: rtl/lcd_text_rom.sv
// Fixed text for the LCD: the four 16-character status messages and the
// line-1 template. Purely combinational, indexed by message and column.
module lcd_text_rom
   import lcd_pkg::*;
(
   input  logic [2:0] sel_i,
   input  logic [3:0] col_i,
   output logic [7:0] char_o
);

   logic [8*LINE_LEN-1:0] lineText;

   // Pick the whole 16-character line, then extract the requested column
   // (column 0 is the leftmost character, held in the top byte)
   always_comb begin
      lineText = {LINE_LEN{ASCII_SPACE}};
      case (sel_i)
         {1'b0, ST_IDLE}:  lineText = "PRESS SPACE     ";
         {1'b0, ST_PLAY}:  lineText = "PLAYING         ";
         {1'b0, ST_OVER}:  lineText = "GAME OVER       ";
         {1'b0, ST_PAUSE}: lineText = "PAUSED          ";
         SEL_TEMPLATE:     lineText = "SCORE:          ";
         default:          lineText = {LINE_LEN{ASCII_SPACE}};
      endcase
      char_o = lineText[{~col_i, 3'b000} +: 8];
   end

endmodule

// File: rtl/lcd_status_sequencer.sv
// Single owner of the LCD RAM write port. Paints line 1 after reset, then
// arbitrates between score redraws (three ASCII digits, leading zeros
// blanked) and status-line redraws (16-character message on line 2).
// Score always wins when both are pending; bursts are never interrupted.
module lcd_status_sequencer
   import lcd_pkg::*;
#(
   parameter int ADDR_W      = 5,
   parameter int SCORE_W     = 8,
   parameter int SCORE_COL   = 7,
   parameter int STATUS_BASE = 16
)(
   input  logic               CLOCK_50,
   input  logic               reset,
   input  logic [SCORE_W-1:0] score,
   input  logic [1:0]         status,
   output logic [ADDR_W-1:0]  lcd_waddr,
   output logic [7:0]         lcd_din,
   output logic               lcd_we,
   output logic               busy
);

   localparam logic [ADDR_W-1:0]  SCORE_ADDR  = ADDR_W'(SCORE_COL);
   localparam logic [ADDR_W-1:0]  STATUS_ADDR = ADDR_W'(STATUS_BASE);
   localparam logic [SCORE_W-1:0] HUNDRED     = SCORE_W'(100);
   localparam logic [SCORE_W-1:0] TEN         = SCORE_W'(10);
   localparam logic [3:0]         LAST_COL    = 4'(LINE_LEN - 1);
   localparam logic [3:0]         LAST_DIGIT  = 4'd2;

   lcd_state_e state_q, state_d;

   logic [3:0]         cnt_q;
   logic [SCORE_W-1:0] rem_q;
   logic [3:0]         hund_q;
   logic [3:0]         tens_q;
   logic [SCORE_W-1:0] lastScore_q;
   logic               scoreOk_q;
   status_e            lastStatus_q;
   logic               statusOk_q;

   logic               lcdWe_q, lcdWe_d;
   logic [ADDR_W-1:0]  lcdWaddr_q, lcdWaddr_d;
   logic [7:0]         lcdDin_q, lcdDin_d;
   logic               busy_q;

   logic               scorePend;
   logic               statPend;
   logic [2:0]         romSel;
   logic [7:0]         romChar;

   // A requester is pending until its current value has been drawn once
   assign scorePend = !scoreOk_q  || (score  != lastScore_q);
   assign statPend  = !statusOk_q || (status != lastStatus_q);

   // Line-1 template while painting INIT, otherwise the latched status message
   assign romSel = (state_q == STAT_WR) ? {1'b0, lastStatus_q} : SEL_TEMPLATE;

   lcd_text_rom u_textRom (
      .sel_i  (romSel),
      .col_i  (cnt_q),
      .char_o (romChar)
   );

   // State register; reset restarts the full repaint from INIT
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q <= INIT;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: bursts run to completion, score beats status in IDLE
   always_comb begin
      state_d = state_q;
      case (state_q)
         INIT: begin
            if (cnt_q == LAST_COL) state_d = IDLE;
         end
         IDLE: begin
            if (scorePend)     state_d = CONV_H;
            else if (statPend) state_d = STAT_WR;
         end
         CONV_H: begin
            if (rem_q < HUNDRED) state_d = CONV_T;
         end
         CONV_T: begin
            if (rem_q < TEN) state_d = DIG_WR;
         end
         DIG_WR: begin
            if (cnt_q == LAST_DIGIT) state_d = IDLE;
         end
         STAT_WR: begin
            if (cnt_q == LAST_COL) state_d = IDLE;
         end
         default: state_d = INIT;
      endcase
   end

   // Output decode: one character per cycle while in a write state;
   // address and data hold their last values when nothing is written
   always_comb begin
      lcdWe_d    = 1'b0;
      lcdWaddr_d = lcdWaddr_q;
      lcdDin_d   = lcdDin_q;
      case (state_q)
         INIT: begin
            lcdWe_d    = 1'b1;
            lcdWaddr_d = ADDR_W'(cnt_q);
            lcdDin_d   = romChar;
         end
         STAT_WR: begin
            lcdWe_d    = 1'b1;
            lcdWaddr_d = STATUS_ADDR + ADDR_W'(cnt_q);
            lcdDin_d   = romChar;
         end
         DIG_WR: begin
            lcdWe_d    = 1'b1;
            lcdWaddr_d = SCORE_ADDR + ADDR_W'(cnt_q);
            case (cnt_q)
               4'd0:    lcdDin_d = (hund_q == 4'd0) ? ASCII_SPACE : digitChar(hund_q);
               4'd1:    lcdDin_d = ((hund_q == 4'd0) && (tens_q == 4'd0)) ? ASCII_SPACE
                                                                          : digitChar(tens_q);
               default: lcdDin_d = digitChar(4'(rem_q));
            endcase
         end
         default: begin
            lcdWe_d = 1'b0;
         end
      endcase
   end

   // Burst column counter: restarts on every state change, steps inside bursts
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (state_d != state_q) begin
         cnt_q <= '0;
      end else if ((state_q == INIT) || (state_q == DIG_WR) || (state_q == STAT_WR)) begin
         cnt_q <= cnt_q + 4'd1;
      end
   end

   // Score snapshot and repeated-subtraction conversion; the snapshot is taken
   // when leaving IDLE so a score change mid-update shows up as a new request
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         rem_q       <= '0;
         hund_q      <= '0;
         tens_q      <= '0;
         lastScore_q <= '0;
         scoreOk_q   <= 1'b0;
      end else if ((state_q == IDLE) && (state_d == CONV_H)) begin
         rem_q       <= score;
         lastScore_q <= score;
         scoreOk_q   <= 1'b1;
         hund_q      <= '0;
         tens_q      <= '0;
      end else if ((state_q == CONV_H) && (rem_q >= HUNDRED)) begin
         rem_q  <= rem_q - HUNDRED;
         hund_q <= hund_q + 4'd1;
      end else if ((state_q == CONV_T) && (rem_q >= TEN)) begin
         rem_q  <= rem_q - TEN;
         tens_q <= tens_q + 4'd1;
      end
   end

   // Status snapshot, taken when a status burst starts
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         lastStatus_q <= ST_IDLE;
         statusOk_q   <= 1'b0;
      end else if ((state_q == IDLE) && (state_d == STAT_WR)) begin
         lastStatus_q <= status_e'(status);
         statusOk_q   <= 1'b1;
      end
   end

   // Registered outputs; busy mirrors the state register exactly
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         lcdWe_q    <= 1'b0;
         lcdWaddr_q <= '0;
         lcdDin_q   <= ASCII_SPACE;
         busy_q     <= 1'b1;
      end else begin
         lcdWe_q    <= lcdWe_d;
         lcdWaddr_q <= lcdWaddr_d;
         lcdDin_q   <= lcdDin_d;
         busy_q     <= (state_d != IDLE);
      end
   end

   assign lcd_we    = lcdWe_q;
   assign lcd_waddr = lcdWaddr_q;
   assign lcd_din   = lcdDin_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_lcd_status_sequencer.sv
// Scoreboard bench for lcd_status_sequencer: every stimulus step queues the
// LCD writes it should cause; a monitor pops one entry per write strobe.
module tb_lcd_status_sequencer;

   logic       CLOCK_50 = 1'b0;
   logic       reset;
   logic [7:0] score;
   logic [1:0] status;
   logic [4:0] lcd_waddr;
   logic [7:0] lcd_din;
   logic       lcd_we;
   logic       busy;

   typedef struct packed {
      logic [4:0] addr;
      logic [7:0] data;
   } wr_t;

   wr_t expQ[$];
   int  checks   = 0;
   int  failures = 0;
   int  writeIdx = 0;

   lcd_status_sequencer dut (
      .CLOCK_50  (CLOCK_50),
      .reset     (reset),
      .score     (score),
      .status    (status),
      .lcd_waddr (lcd_waddr),
      .lcd_din   (lcd_din),
      .lcd_we    (lcd_we),
      .busy      (busy)
   );

   // 50 MHz clock
   always #10 CLOCK_50 = ~CLOCK_50;

   // Single comparison with failure reporting
   task automatic checkOutput(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   // Queue a 16-character line starting at base, space padded
   task automatic pushText(input int base, input string text);
      for (int i = 0; i < 16; i++) begin
         wr_t e;
         e.addr = 5'(base + i);
         e.data = (i < text.len()) ? text[i] : 8'h20;
         expQ.push_back(e);
      end
   endtask

   // Queue the three score cells 7, 8, 9 with hand-written characters
   task automatic pushDigits(input string d3);
      for (int i = 0; i < 3; i++) begin
         wr_t e;
         e.addr = 5'(7 + i);
         e.data = d3[i];
         expQ.push_back(e);
      end
   endtask

   // Change inputs just after a rising edge
   task automatic applyStimulus(input logic [7:0] newScore, input logic [1:0] newStatus);
      @(posedge CLOCK_50);
      #1;
      score  = newScore;
      status = newStatus;
   endtask

   // Wait until busy has been low for two samples, then confirm nothing is left
   task automatic waitQuiet(input string name);
      int quiet = 0;
      int n     = 0;
      while (quiet < 2 && n < 300) begin
         @(negedge CLOCK_50);
         n++;
         if (busy === 1'b0) quiet++;
         else               quiet = 0;
      end
      checkOutput({name, " quiet"}, int'(quiet >= 2), 1);
      checkOutput({name, " drained"}, expQ.size(), 0);
      checkOutput({name, " idle_we"}, int'(lcd_we), 0);
   endtask

   // Rising edges from the input change until the ones digit (addr 9) is written
   task automatic measureLatency(input string name, input int expLat);
      int  lat  = 0;
      bit  seen = 1'b0;
      for (int k = 1; k <= 40 && !seen; k++) begin
         @(posedge CLOCK_50);
         @(negedge CLOCK_50);
         if (lcd_we === 1'b1 && lcd_waddr == 5'd9) begin
            seen = 1'b1;
            lat  = k;
         end
      end
      checkOutput({name, " latency"}, lat, expLat);
   endtask

   // Block until a write to the given address is observed (bounded)
   task automatic waitWrite(input string name, input logic [4:0] addr);
      bit seen = 1'b0;
      for (int k = 0; k < 100 && !seen; k++) begin
         @(negedge CLOCK_50);
         if (lcd_we === 1'b1 && lcd_waddr == addr) seen = 1'b1;
      end
      checkOutput({name, " seen"}, int'(seen), 1);
   endtask

   // Monitor: every write strobe must match the head of the expected queue
   always @(negedge CLOCK_50) begin
      wr_t e;
      if (lcd_we === 1'b1) begin
         checks++;
         if (expQ.size() == 0) begin
            failures++;
            $display("[TB] FAIL unexpected write: addr=%0d data=0x%02h", lcd_waddr, lcd_din);
         end else begin
            e = expQ.pop_front();
            if (lcd_waddr !== e.addr || lcd_din !== e.data) begin
               failures++;
               $display("[TB] FAIL write%0d: got addr=%0d data=0x%02h expected addr=%0d data=0x%02h",
                        writeIdx, lcd_waddr, lcd_din, e.addr, e.data);
            end
         end
         writeIdx++;
      end
   end

   // Safety net in case something stalls outside the bounded waits
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "[TB] watchdog");
   end

   // Directed test sequence
   initial begin
      reset  = 1'b1;
      score  = 8'd0;
      status = 2'd0;
      repeat (2) @(posedge CLOCK_50);
      #1;
      $display("[TB] reset state");
      checkOutput("reset lcd_we",    int'(lcd_we),    0);
      checkOutput("reset lcd_waddr", int'(lcd_waddr), 0);
      checkOutput("reset lcd_din",   int'(lcd_din),   32'h20);
      checkOutput("reset busy",      int'(busy),      1);

      $display("[TB] power-up repaint");
      pushText(0, "SCORE:");
      pushDigits("  0");
      pushText(16, "PRESS SPACE");
      reset = 1'b0;
      waitQuiet("powerup");

      $display("[TB] score 255");
      pushDigits("255");
      applyStimulus(8'd255, 2'd0);
      measureLatency("score255", 13);
      waitQuiet("score255");

      $display("[TB] status playing");
      pushText(16, "PLAYING");
      applyStimulus(8'd255, 2'd1);
      waitQuiet("status1");

      $display("[TB] score 199 and status game over together");
      pushDigits("199");
      pushText(16, "GAME OVER");
      applyStimulus(8'd199, 2'd2);
      measureLatency("score199", 16);
      waitQuiet("score199");

      $display("[TB] score 10 then 11 during digit write");
      pushDigits(" 10");
      applyStimulus(8'd10, 2'd2);
      waitWrite("score10 hund", 5'd7);
      #1;
      pushDigits(" 11");
      score = 8'd11;
      waitQuiet("score11");

      $display("[TB] leading zero blanking");
      pushDigits("  5");
      applyStimulus(8'd5, 2'd2);
      waitQuiet("score5");
      pushDigits(" 40");
      applyStimulus(8'd40, 2'd2);
      waitQuiet("score40");

      $display("[TB] reset during status burst");
      pushText(16, "PAUSED");
      applyStimulus(8'd40, 2'd3);
      waitWrite("paused addr20", 5'd20);
      #1;
      reset = 1'b1;
      @(posedge CLOCK_50);
      #1;
      checkOutput("midreset lcd_we",    int'(lcd_we),    0);
      checkOutput("midreset busy",      int'(busy),      1);
      checkOutput("midreset lcd_waddr", int'(lcd_waddr), 0);
      checkOutput("midreset lcd_din",   int'(lcd_din),   32'h20);
      expQ.delete();
      pushText(0, "SCORE:");
      pushDigits(" 40");
      pushText(16, "PAUSED");
      @(posedge CLOCK_50);
      #1;
      reset = 1'b0;
      waitQuiet("rerun");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
